e203_mt_perf_mon: RTL and testbench
===================================

# e203_mt_perf_mon

Synthesizable per-thread performance and commit-trace monitor for the multithreaded E203 core. It is instantiated next to the IFU/EXU inside the CPU top and taps thread-select, switch and commit signals. It keeps a global cycle counter, a thread-switch counter, and per-thread fetch-cycle and commit counters. It also buffers a (thread id, PC) commit trace that a debug or bench agent drains through a valid/ready port.

## Interface
- THREADS_NUM, 2: hardware thread count, ≥2
- PC_SIZE, 32: PC width
- CNT_W, 32: counter width
- TRACE_DEPTH, 8: trace FIFO entries, power of two ≥2
- TID_W, $clog2(THREADS_NUM): encoded thread-id width
- RD_AW, $clog2(3+2*THREADS_NUM): read address width

Ports:
- hfclk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear of all counters, flags and FIFO
- ifu_thread_sel  in  THREADS_NUM  one-hot thread currently fetching
- switch_en  in  1  IFU thread-switch strobe
- commit_valid  in  1  EXU commits one instruction this cycle
- exu_thread_sel  in  THREADS_NUM  one-hot thread of committing instruction
- commit_pc  in  PC_SIZE  PC of committing instruction
- rd_en  in  1  counter read request
- rd_addr  in  RD_AW  counter select
- rd_data  out  CNT_W  registered read data
- sel_err  out  1  sticky: commit seen with non-one-hot exu_thread_sel
- trc_valid  out  1  trace head entry valid
- trc_ready  in  1  consumer accepts head entry
- trc_tid  out  TID_W  head entry thread id
- trc_pc  out  PC_SIZE  head entry PC
- trc_ovf  out  1  sticky: at least one trace entry dropped

## Operation
- cycle_cnt: +1 every cycle out of reset.
- switch_cnt: +1 on each cycle with switch_en=1.
- fetch_cnt[t]: +1 when ifu_thread_sel[t]=1. Multi-hot selects increment every selected thread.
- commit_cnt[t]: +1 when commit_valid and exu_thread_sel is one-hot with bit t set.
- A commit with a zero or multi-hot exu_thread_sel is not counted per thread and sets sel_err.
- All counters wrap modulo 2^CNT_W with no saturation.
- Read map:
  - 0: cycle_cnt
  - 1: switch_cnt
  - 2+2t: fetch_cnt[t]
  - 3+2t: commit_cnt[t]
  - 2+2*THREADS_NUM: drop_cnt
  - Any other address returns 0.
- Trace push: every valid commit pushes {tid, commit_pc}. tid is the one-hot encoded thread id; for a non-one-hot select it is the lowest set bit, or 0 if none.
- Trace pop: occurs when trc_valid && trc_ready.
- Full FIFO: a push is accepted only if a pop happens in the same cycle. Otherwise the entry is dropped, drop_cnt +1 and trc_ovf is set.
- Empty FIFO: trc_valid=0, and trc_tid/trc_pc are held at their last value (0 after reset).
- clr beats every same-cycle increment, push, pop and flag set. After clr all counters, sel_err, trc_ovf and the FIFO are zero/empty.

## Timing
- Reset values: rd_data=0, sel_err=0, trc_valid=0, trc_tid=0, trc_pc=0, trc_ovf=0, all counters 0.
- Counters update on posedge hfclk, so the event in cycle N is visible to a read issued in cycle N+1.
- rd_data is loaded one cycle after rd_en and holds until the next rd_en. A read in the same cycle as an increment returns the pre-increment value.
- Trace: an entry pushed in cycle N gives trc_valid=1 in cycle N+1 (FIFO, no bypass). Sustained throughput is 1 push and 1 pop per cycle.
- trc_tid/trc_pc must stay stable while trc_valid && !trc_ready.
- rst_n assertion mid-operation clears all state asynchronously and discards in-flight entries.

## Configuration
- E203_MT_TRACE_EN defined: trace FIFO, trc_* ports, drop_cnt and trc_ovf are fully implemented.
- Undefined: no FIFO storage is built. trc_valid, trc_tid, trc_pc and trc_ovf are tied 0, and drop_cnt reads 0. Counters and sel_err are unchanged.

## Structure
- Shared package e203_mt_perf_pkg holds:
  - read-address constants (ADDR_CYCLE, ADDR_SWITCH, ADDR_FETCH_BASE, ADDR_COMMIT_BASE, ADDR_DROP)
  - the one-hot-to-index and one-hot-check functions
- Sub-module e203_mt_trace_fifo is the parametrised synchronous valid/ready FIFO of width TID_W+PC_SIZE with a full-with-pop accept rule. It is compiled only under E203_MT_TRACE_EN.

## Test plan
- Reset, then 100 idle cycles; read addr 0 → 100 (±1 per read latency), addrs 1..2+2*THREADS_NUM → 0.
- Alternate ifu_thread_sel 01/10 for 10 cycles with switch_en every cycle → fetch_cnt[0]=5, fetch_cnt[1]=5, switch_cnt=10.
- 3 commits thread 1 (PC 0x80000000, 0x80000004, 0x80000008), trc_ready=1 → commit_cnt[1]=3, trace outputs tid=1 with those PCs in order, each one cycle after its push.
- trc_ready=0, 10 commits with TRACE_DEPTH=8 → 8 entries held, drop_cnt=2, trc_ovf=1; then full with a simultaneous push and pop → push accepted, drop_cnt stays 2.
- Commit with exu_thread_sel=2'b11 → sel_err=1, neither commit_cnt changes; then clr → sel_err=0, trc_ovf=0, all counters 0, trc_valid=0.
- Preload CNT_W=8 build with 255 fetch cycles on thread 0, then one more → fetch_cnt[0]=0 (wrap).

Source files
------------

// File: rtl/e203_mt_perf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : e203_mt_perf_pkg
// Purpose  : Shared definitions for the multithreaded E203 performance
//            monitor: counter read-address map and thread-select helpers.
// Revision : 1.0 - initial release
// ============================================================================
package e203_mt_perf_pkg;

    // Read-address map. Per-thread counters are interleaved: fetch_cnt[t]
    // lives at ADDR_FETCH_BASE + ADDR_STRIDE*t and commit_cnt[t] at
    // ADDR_COMMIT_BASE + ADDR_STRIDE*t.
    localparam int ADDR_CYCLE       = 0;
    localparam int ADDR_SWITCH      = 1;
    localparam int ADDR_FETCH_BASE  = 2;
    localparam int ADDR_COMMIT_BASE = 3;
    localparam int ADDR_STRIDE      = 2;

    // Widest thread-select vector the helpers accept; callers zero-extend.
    localparam int SEL_MAX_W = 32;

    // The drop counter sits just above the last per-thread counter, so its
    // address depends on the thread count of the instantiating module.
    function automatic int ADDR_DROP(input int threads_num);
        return ADDR_FETCH_BASE + ADDR_STRIDE * threads_num;
    endfunction

    // True when exactly one bit of sel is set.
    function automatic logic is_onehot(input logic [SEL_MAX_W-1:0] sel);
        return (sel != '0) && ((sel & (sel - SEL_MAX_W'(1))) == '0);
    endfunction

    // Index of the lowest set bit; 0 when no bit is set. For a proper
    // one-hot input this is the binary encoding of the select.
    function automatic int onehot_idx(input logic [SEL_MAX_W-1:0] sel);
        int idx;
        idx = 0;
        for (int i = SEL_MAX_W - 1; i >= 0; i--) begin
            if (sel[i]) idx = i;
        end
        return idx;
    endfunction

endpackage : e203_mt_perf_pkg
`default_nettype wire

// File: rtl/e203_mt_perf_mon_if.sv
`default_nettype none
// ============================================================================
// Module   : e203_mt_perf_mon_if
// Purpose  : Commit-trace drain port of the MT performance monitor.
//            master : the monitor (drives valid / tid / pc / ovf)
//            slave  : the consumer (drives ready)
// Ports    : trc_valid, trc_ready, trc_tid[TID_W], trc_pc[PC_SIZE], trc_ovf
// Revision : 1.0 - initial release
// ============================================================================
interface e203_mt_perf_mon_if #(
    parameter int TID_W   = 1,
    parameter int PC_SIZE = 32
);
    logic               trc_valid;
    logic               trc_ready;
    logic [TID_W-1:0]   trc_tid;
    logic [PC_SIZE-1:0] trc_pc;
    logic               trc_ovf;

    modport master (
        output trc_valid,
        output trc_tid,
        output trc_pc,
        output trc_ovf,
        input  trc_ready
    );

    modport slave (
        input  trc_valid,
        input  trc_tid,
        input  trc_pc,
        input  trc_ovf,
        output trc_ready
    );
endinterface : e203_mt_perf_mon_if
`default_nettype wire

// File: rtl/e203_mt_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : e203_mt_trace_fifo
// Purpose  : Synchronous valid/ready FIFO for commit-trace entries. When
//            full, a push is accepted only if the head is popped in the same
//            cycle; otherwise it is dropped and push_drop pulses. While empty
//            the output holds the last popped entry (0 after reset/clr).
//            Built only when E203_MT_TRACE_EN is defined.
// Ports    : hfclk, rst_n (async, active-low), clr (sync clear)
//            push_valid/push_data/push_drop  - producer side
//            pop_valid/pop_data/pop_ready    - consumer side
// Revision : 1.0 - initial release
// ============================================================================
`ifdef E203_MT_TRACE_EN
module e203_mt_trace_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  wire logic             hfclk,
    input  wire logic             rst_n,
    input  wire logic             clr,
    input  wire logic             push_valid,
    input  wire logic [WIDTH-1:0] push_data,
    output logic                  push_drop,
    output logic                  pop_valid,
    output logic [WIDTH-1:0]      pop_data,
    input  wire logic             pop_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] last_q;
    logic             empty;
    logic             full;
    logic             pop;
    logic             accept;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = !empty && pop_ready;
    // On a full FIFO the slot being written is the one the pop frees.
    assign accept    = push_valid && (!full || pop);
    assign push_drop = push_valid && full && !pop;

    assign pop_valid = !empty;
    assign pop_data  = empty ? last_q : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last_q <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last_q <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                last_q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // Storage needs no reset: it is only observable through the pointers.
    always_ff @(posedge hfclk) begin
        if (accept && !clr) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule : e203_mt_trace_fifo
`endif
`default_nettype wire

// File: rtl/e203_mt_perf_mon.sv
`default_nettype none
// ============================================================================
// Module   : e203_mt_perf_mon
// Purpose  : Per-thread performance and commit-trace monitor for the
//            multithreaded E203. Counts cycles, thread switches, per-thread
//            fetch cycles and commits; buffers a (tid, PC) commit trace.
// Macro    : E203_MT_TRACE_EN - builds the trace FIFO, drop_cnt and trc_ovf.
//            Without it the trace port is tied to 0 and drop_cnt reads 0.
// Ports    : hfclk, rst_n (async, active-low), clr (sync clear)
//            ifu_thread_sel, switch_en                   - IFU taps
//            commit_valid, exu_thread_sel, commit_pc     - EXU commit taps
//            rd_en, rd_addr, rd_data                     - counter read port
//            sel_err                                     - sticky bad select
//            trc (e203_mt_perf_mon_if.master)            - trace drain port
// Revision : 1.0 - initial release
// ============================================================================
module e203_mt_perf_mon
    import e203_mt_perf_pkg::*;
#(
    parameter int THREADS_NUM = 2,
    parameter int PC_SIZE     = 32,
    parameter int CNT_W       = 32,
    parameter int TRACE_DEPTH = 8,
    parameter int TID_W       = $clog2(THREADS_NUM),
    parameter int RD_AW       = $clog2(3 + 2 * THREADS_NUM)
) (
    input  wire logic                   hfclk,
    input  wire logic                   rst_n,
    input  wire logic                   clr,
    input  wire logic [THREADS_NUM-1:0] ifu_thread_sel,
    input  wire logic                   switch_en,
    input  wire logic                   commit_valid,
    input  wire logic [THREADS_NUM-1:0] exu_thread_sel,
    input  wire logic [PC_SIZE-1:0]     commit_pc,
    input  wire logic                   rd_en,
    input  wire logic [RD_AW-1:0]       rd_addr,
    output logic [CNT_W-1:0]            rd_data,
    output logic                        sel_err,
    e203_mt_perf_mon_if.master          trc
);
    localparam int              DROP_ADDR = ADDR_DROP(THREADS_NUM);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    logic [CNT_W-1:0]                  cycle_cnt;
    logic [CNT_W-1:0]                  switch_cnt;
    logic [CNT_W-1:0]                  drop_cnt;
    logic [THREADS_NUM-1:0][CNT_W-1:0] fetch_cnt;
    logic [THREADS_NUM-1:0][CNT_W-1:0] commit_cnt;
    logic [CNT_W-1:0]                  rd_mux;
    logic [SEL_MAX_W-1:0]              exu_sel_ext;
    logic                              sel_onehot;
    logic                              commit_ok;

    assign exu_sel_ext = SEL_MAX_W'(exu_thread_sel);
    assign sel_onehot  = is_onehot(exu_sel_ext);
    assign commit_ok   = commit_valid && sel_onehot;

    // ------------------------------------------------------------------
    // Event counters (free-running, wrap modulo 2^CNT_W)
    // ------------------------------------------------------------------
    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt  <= '0;
            switch_cnt <= '0;
            fetch_cnt  <= '0;
            commit_cnt <= '0;
        end else if (clr) begin
            cycle_cnt  <= '0;
            switch_cnt <= '0;
            fetch_cnt  <= '0;
            commit_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
            if (switch_en) switch_cnt <= switch_cnt + CNT_ONE;
            for (int t = 0; t < THREADS_NUM; t++) begin
                // Multi-hot fetch selects count on every selected thread.
                if (ifu_thread_sel[t]) fetch_cnt[t] <= fetch_cnt[t] + CNT_ONE;
                if (commit_ok && exu_thread_sel[t])
                    commit_cnt[t] <= commit_cnt[t] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (clr) begin
            sel_err <= 1'b0;
        end else if (commit_valid && !sel_onehot) begin
            sel_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read port: combinational select, registered on rd_en so a read in
    // the same cycle as an increment returns the pre-increment value.
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        if (int'(rd_addr) == ADDR_CYCLE)  rd_mux = cycle_cnt;
        if (int'(rd_addr) == ADDR_SWITCH) rd_mux = switch_cnt;
        if (int'(rd_addr) == DROP_ADDR)   rd_mux = drop_cnt;
        for (int t = 0; t < THREADS_NUM; t++) begin
            if (int'(rd_addr) == ADDR_FETCH_BASE + ADDR_STRIDE * t)
                rd_mux = fetch_cnt[t];
            if (int'(rd_addr) == ADDR_COMMIT_BASE + ADDR_STRIDE * t)
                rd_mux = commit_cnt[t];
        end
    end

    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_mux;
        end
    end

    // ------------------------------------------------------------------
    // Commit trace
    // ------------------------------------------------------------------
`ifdef E203_MT_TRACE_EN
    localparam int ENTRY_W = TID_W + PC_SIZE;

    logic [TID_W-1:0]   commit_tid;
    logic [ENTRY_W-1:0] head_entry;
    logic               push_drop;
    logic               trc_ovf_q;

    // Non-one-hot selects still trace, tagged with the lowest set bit.
    assign commit_tid = TID_W'(onehot_idx(exu_sel_ext));

    e203_mt_trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .hfclk      (hfclk),
        .rst_n      (rst_n),
        .clr        (clr),
        .push_valid (commit_valid),
        .push_data  ({commit_tid, commit_pc}),
        .push_drop  (push_drop),
        .pop_valid  (trc.trc_valid),
        .pop_data   (head_entry),
        .pop_ready  (trc.trc_ready)
    );

    always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt  <= '0;
            trc_ovf_q <= 1'b0;
        end else if (clr) begin
            drop_cnt  <= '0;
            trc_ovf_q <= 1'b0;
        end else if (push_drop) begin
            drop_cnt  <= drop_cnt + CNT_ONE;
            trc_ovf_q <= 1'b1;
        end
    end

    assign trc.trc_tid = head_entry[PC_SIZE +: TID_W];
    assign trc.trc_pc  = head_entry[PC_SIZE-1:0];
    assign trc.trc_ovf = trc_ovf_q;
`else
    logic unused_trace;

    assign drop_cnt      = '0;
    assign trc.trc_valid = 1'b0;
    assign trc.trc_tid   = '0;
    assign trc.trc_pc    = '0;
    assign trc.trc_ovf   = 1'b0;
    assign unused_trace  = trc.trc_ready ^ (^commit_pc);
`endif

endmodule : e203_mt_perf_mon
`default_nettype wire

// File: tb/tb_e203_mt_perf_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_e203_mt_perf_mon
// Purpose  : Self-checking bench for e203_mt_perf_mon (THREADS_NUM=2,
//            CNT_W=8 so counter wrap is reachable). Trace expectations follow
//            whether E203_MT_TRACE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e203_mt_perf_mon;
    localparam int THREADS_NUM = 2;
    localparam int PC_SIZE     = 32;
    localparam int CNT_W       = 8;
    localparam int TRACE_DEPTH = 8;
    localparam int TID_W       = 1;
    localparam int RD_AW       = 3;
`ifdef E203_MT_TRACE_EN
    localparam bit TRC_EN = 1'b1;
`else
    localparam bit TRC_EN = 1'b0;
`endif

    logic                   hfclk;
    logic                   rst_n;
    logic                   clr;
    logic [THREADS_NUM-1:0] ifu_thread_sel;
    logic                   switch_en;
    logic                   commit_valid;
    logic [THREADS_NUM-1:0] exu_thread_sel;
    logic [PC_SIZE-1:0]     commit_pc;
    logic                   rd_en;
    logic [RD_AW-1:0]       rd_addr;
    logic [CNT_W-1:0]       rd_data;
    logic                   sel_err;

    e203_mt_perf_mon_if #(.TID_W(TID_W), .PC_SIZE(PC_SIZE)) trc ();

    e203_mt_perf_mon #(
        .THREADS_NUM (THREADS_NUM),
        .PC_SIZE     (PC_SIZE),
        .CNT_W       (CNT_W),
        .TRACE_DEPTH (TRACE_DEPTH),
        .TID_W       (TID_W),
        .RD_AW       (RD_AW)
    ) dut (
        .hfclk          (hfclk),
        .rst_n          (rst_n),
        .clr            (clr),
        .ifu_thread_sel (ifu_thread_sel),
        .switch_en      (switch_en),
        .commit_valid   (commit_valid),
        .exu_thread_sel (exu_thread_sel),
        .commit_pc      (commit_pc),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .sel_err        (sel_err),
        .trc            (trc)
    );

    initial hfclk = 1'b0;
    always #5 hfclk = ~hfclk;

    int n_vec = 0;
    int n_err = 0;
    int n_pops = 0;

    // Reference model state
    logic [CNT_W-1:0]     m_cycle, m_switch, m_drop;
    logic [CNT_W-1:0]     m_fetch [THREADS_NUM];
    logic [CNT_W-1:0]     m_commit[THREADS_NUM];
    logic                 m_selerr, m_ovf;
    logic [CNT_W-1:0]     m_rd_last;
    logic [TID_W+PC_SIZE-1:0] m_last;
    logic [TID_W+PC_SIZE-1:0] trq[$];  // expected trace entries
    logic [CNT_W-1:0]         rdq[$];  // expected read results

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_cycle = '0; m_switch = '0; m_drop = '0;
        for (int t = 0; t < THREADS_NUM; t++) begin
            m_fetch[t] = '0; m_commit[t] = '0;
        end
        m_selerr = 1'b0; m_ovf = 1'b0; m_last = '0;
        trq.delete();
    endtask

    function automatic logic [CNT_W-1:0] model_read(input int a);
        case (a)
            0: return m_cycle;
            1: return m_switch;
            2: return m_fetch[0];
            3: return m_commit[0];
            4: return m_fetch[1];
            5: return m_commit[1];
            6: return m_drop;
            default: return '0;
        endcase
    endfunction

    // One clock cycle with the currently driven inputs.
    task automatic step();
        bit pop;
        bit rd_pend;
        logic [TID_W+PC_SIZE-1:0] e;
        logic [TID_W-1:0] tid;
        // Trace head observed before the edge
        check("trc_valid", trc.trc_valid, trq.size() != 0);
        e = (trq.size() != 0) ? trq[0] : m_last;
        check("trc_tid", trc.trc_tid, e[PC_SIZE +: TID_W]);
        check("trc_pc", trc.trc_pc, e[PC_SIZE-1:0]);
        pop = (trq.size() != 0) && trc.trc_ready;
        if (pop) begin
            m_last = trq.pop_front();
            n_pops++;
        end
        rd_pend = rd_en;
        if (rd_en) rdq.push_back(model_read(int'(rd_addr)));
        if (clr) begin
            model_clear();
        end else begin
            m_cycle++;
            if (switch_en) m_switch++;
            for (int t = 0; t < THREADS_NUM; t++)
                if (ifu_thread_sel[t]) m_fetch[t]++;
            if (commit_valid) begin
                if ($countones(exu_thread_sel) == 1) begin
                    for (int t = 0; t < THREADS_NUM; t++)
                        if (exu_thread_sel[t]) m_commit[t]++;
                end else begin
                    m_selerr = 1'b1;
                end
                if (TRC_EN) begin
                    tid = '0;
                    for (int t = THREADS_NUM - 1; t >= 0; t--)
                        if (exu_thread_sel[t]) tid = TID_W'(t);
                    if (trq.size() < TRACE_DEPTH) begin
                        trq.push_back({tid, commit_pc});
                    end else begin
                        m_drop++;
                        m_ovf = 1'b1;
                    end
                end
            end
        end
        @(posedge hfclk);
        #1;
        if (rd_pend) m_rd_last = rdq.pop_front();
        check("rd_data", rd_data, m_rd_last);
        check("sel_err", sel_err, m_selerr);
        check("trc_ovf", trc.trc_ovf, m_ovf);
    endtask

    task automatic do_read(input int a);
        rd_en = 1'b1;
        rd_addr = RD_AW'(a);
        step();
        rd_en = 1'b0;
    endtask

    task automatic commit(input logic [THREADS_NUM-1:0] sel, input logic [PC_SIZE-1:0] pc);
        commit_valid = 1'b1;
        exu_thread_sel = sel;
        commit_pc = pc;
        step();
        commit_valid = 1'b0;
        exu_thread_sel = '0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; ifu_thread_sel = '0; switch_en = 1'b0;
        commit_valid = 1'b0; exu_thread_sel = '0; commit_pc = '0;
        rd_en = 1'b0; rd_addr = '0; trc.trc_ready = 1'b0;
        model_clear();
        m_rd_last = '0;
        repeat (3) @(posedge hfclk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst_rd_data", rd_data, 0);
        check("rst_sel_err", sel_err, 0);
        check("rst_trc_valid", trc.trc_valid, 0);
        check("rst_trc_tid", trc.trc_tid, 0);
        check("rst_trc_pc", trc.trc_pc, 0);
        check("rst_trc_ovf", trc.trc_ovf, 0);

        // Idle, then read the whole map including an unmapped address
        repeat (100) step();
        for (int a = 0; a < 8; a++) do_read(a);
        step();  // rd_data must hold

        // Alternating fetch select with a switch strobe every cycle
        for (int i = 0; i < 10; i++) begin
            ifu_thread_sel = (i % 2 == 0) ? 2'b01 : 2'b10;
            switch_en = 1'b1;
            step();
        end
        ifu_thread_sel = '0; switch_en = 1'b0;
        do_read(1); do_read(2); do_read(4);
        ifu_thread_sel = 2'b11;  // multi-hot fetch counts both threads
        step();
        ifu_thread_sel = '0;
        do_read(2); do_read(4);

        // Three thread-1 commits drained as they arrive
        trc.trc_ready = 1'b1;
        commit(2'b10, 32'h8000_0000);
        commit(2'b10, 32'h8000_0004);
        commit(2'b10, 32'h8000_0008);
        repeat (3) step();
        do_read(5);
        check("trc_pops", n_pops, TRC_EN ? 3 : 0);

        // Back-pressure: overfill, then a full push with a same-cycle pop
        trc.trc_ready = 1'b0;
        for (int i = 0; i < 10; i++) commit(2'b01, 32'h0000_1000 + 32'(4 * i));
        do_read(6);
        trc.trc_ready = 1'b1;
        commit(2'b01, 32'h0000_2000);
        trc.trc_ready = 1'b0;
        do_read(6);
        do_read(3);
        trc.trc_ready = 1'b1;
        repeat (10) step();

        // Bad commit select, then synchronous clear
        commit(2'b11, 32'h0000_3000);
        step();
        do_read(3); do_read(5);
        commit(2'b00, 32'h0000_3004);
        clr = 1'b1;
        ifu_thread_sel = 2'b01; switch_en = 1'b1;  // clr wins over these
        commit(2'b01, 32'h0000_3008);
        clr = 1'b0; ifu_thread_sel = '0; switch_en = 1'b0;
        for (int a = 0; a < 8; a++) do_read(a);

        // Counter wrap at 2^CNT_W
        ifu_thread_sel = 2'b01;
        repeat (255) step();
        ifu_thread_sel = '0;
        do_read(2);
        ifu_thread_sel = 2'b01;
        step();
        ifu_thread_sel = '0;
        do_read(2);

        // Asynchronous reset mid-cycle with trace entries in flight
        trc.trc_ready = 1'b0;
        commit(2'b10, 32'h0000_4000);
        commit(2'b11, 32'h0000_4004);
        do_read(0);
        #3 rst_n = 1'b0;
        #1;
        check("arst_rd_data", rd_data, 0);
        check("arst_sel_err", sel_err, 0);
        check("arst_trc_valid", trc.trc_valid, 0);
        check("arst_trc_pc", trc.trc_pc, 0);
        model_clear();
        rdq.delete();
        m_rd_last = '0;
        @(posedge hfclk);
        #1 rst_n = 1'b1;
        repeat (4) step();
        do_read(0); do_read(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule : tb_e203_mt_perf_mon
`default_nettype wire
